// File: rtl/demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// demux_1x2_stream
//
// Registered 1-to-2 stream demultiplexer. Each word offered on the single
// valid/ready input is steered to output A (in_sel = 0) or output B
// (in_sel = 1). Every output has its own buffer, so a stalled consumer on one
// side never blocks, corrupts or drops words bound for the other side.
//
// Build option:
//   DEMUX_SKID_EN undefined : one-entry register per output; in_ready depends
//                             combinationally on the selected x_ready.
//   DEMUX_SKID_EN defined   : two-entry skid FIFO per output; in_ready comes
//                             from registered occupancy only.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   in_data    in   [WIDTH] word to route
//   in_sel     in   destination select, 0 = A, 1 = B (sampled with in_data)
//   in_valid   in   source offers a word
//   in_ready   out  word accepted this cycle when in_valid is also high
//   a_data     out  [WIDTH] head word for consumer A
//   a_valid    out  a_data is valid
//   a_ready    in   consumer A takes the word
//   b_data/b_valid/b_ready : same as A, for consumer B
//   a_count    out  [8] words delivered on A, wraps modulo 256
//   b_count    out  [8] words delivered on B, wraps modulo 256
// -----------------------------------------------------------------------------
module demux_1x2_stream #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  // Index 0 is output A, index 1 is output B; both paths share one body.
  localparam int NOUT = 2;

  logic [WIDTH-1:0] r_head  [NOUT];  // word presented to the consumer
`ifdef DEMUX_SKID_EN
  logic [WIDTH-1:0] r_tail  [NOUT];  // second (skid) entry behind the head
`endif
  logic [1:0]       r_occ   [NOUT];  // buffered words: 0..1, or 0..2 with skid
  logic [7:0]       r_count [NOUT];  // delivered-word counters

  logic [NOUT-1:0]  w_ready;
  logic [NOUT-1:0]  w_pop;
  logic [NOUT-1:0]  w_push;
  logic [NOUT-1:0]  w_can_accept;

  assign w_ready = {b_ready, a_ready};

  for (genvar g = 0; g < NOUT; g++) begin : g_path
    assign w_pop[g] = (r_occ[g] != 2'd0) && w_ready[g];
`ifdef DEMUX_SKID_EN
    // Registered-only ready: a full skid buffer refuses even if the consumer
    // is draining this cycle, which breaks the ready combinational path.
    assign w_can_accept[g] = (r_occ[g] != 2'd2);
`else
    // Single register: accept when empty or when the head leaves this cycle.
    assign w_can_accept[g] = (r_occ[g] == 2'd0) || w_ready[g];
`endif
  end

  // Only the selected output's state decides readiness.
  assign in_ready  = w_can_accept[in_sel];
  assign w_push[0] = in_valid && in_ready && !in_sel;
  assign w_push[1] = in_valid && in_ready &&  in_sel;

  always_ff @(posedge clk) begin
    for (int k = 0; k < NOUT; k++) begin
      if (!reset_n) begin
        // NOTE: the data registers are reset too, because the outputs must
        // read 0 after reset rather than whatever the flops powered up with.
        r_head[k]  <= '0;
`ifdef DEMUX_SKID_EN
        r_tail[k]  <= '0;
`endif
        r_occ[k]   <= 2'd0;
        r_count[k] <= 8'd0;
      end else begin
        // NOTE: non-blocking assignments throughout, so every path sees the
        // pre-edge occupancy no matter the order of the statements below.
        if (w_pop[k]) begin
          r_count[k] <= r_count[k] + 8'd1;
        end
`ifdef DEMUX_SKID_EN
        case (r_occ[k])
          2'd0: begin
            if (w_push[k]) begin
              r_head[k] <= in_data;
              r_occ[k]  <= 2'd1;
            end
          end
          2'd1: begin
            if (w_push[k] && w_pop[k]) begin
              r_head[k] <= in_data;          // reload, occupancy unchanged
            end else if (w_push[k]) begin
              r_tail[k] <= in_data;
              r_occ[k]  <= 2'd2;
            end else if (w_pop[k]) begin
              r_occ[k]  <= 2'd0;
            end
          end
          default: begin
            // Full: no push is possible, only the head can leave.
            if (w_pop[k]) begin
              r_head[k] <= r_tail[k];
              r_occ[k]  <= 2'd1;
            end
          end
        endcase
`else
        if (w_push[k]) begin
          r_head[k] <= in_data;              // also covers push + pop reload
          r_occ[k]  <= 2'd1;
        end else if (w_pop[k]) begin
          r_occ[k]  <= 2'd0;
        end
`endif
      end
    end
  end

  assign a_data  = r_head[0];
  assign b_data  = r_head[1];
  assign a_valid = (r_occ[0] != 2'd0);
  assign b_valid = (r_occ[1] != 2'd0);
  assign a_count = r_count[0];
  assign b_count = r_count[1];

endmodule

// File: tb/tb_demux_1x2_stream.sv
// -----------------------------------------------------------------------------
// tb_demux_1x2_stream
//
// Directed bench for demux_1x2_stream. A queue-based model of the two output
// buffers is compared with the DUT on every falling edge; directed sections
// add literal expectations for reset, steering, stall, streaming, count wrap
// and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_demux_1x2_stream;

  localparam int W = 16;
`ifdef DEMUX_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk;
  logic          reset_n;
  logic [W-1:0]  in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_data;
  logic          a_valid;
  logic          a_ready;
  logic [W-1:0]  b_data;
  logic          b_valid;
  logic          b_ready;
  logic [7:0]    a_count;
  logic [7:0]    b_count;

  demux_1x2_stream #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: one FIFO queue per output plus delivered-word counters.
  // ---------------------------------------------------------------------------
  logic [W-1:0] mq_a[$];
  logic [W-1:0] mq_b[$];
  int           mcnt_a = 0;
  int           mcnt_b = 0;
  bit           m_live = 1'b0;
  bit           m_acc;

  function automatic bit m_rdy(input bit sel);
    int sz;
    bit cr;
    sz = sel ? mq_b.size() : mq_a.size();
    cr = sel ? b_ready : a_ready;
    if (CAP == 1) return (sz == 0) || cr;
    return sz < CAP;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      mq_a.delete();
      mq_b.delete();
      mcnt_a = 0;
      mcnt_b = 0;
      m_live = 1'b1;
    end else begin
      m_acc = in_valid && m_rdy(in_sel);
      if (mq_a.size() != 0 && a_ready) begin
        void'(mq_a.pop_front());
        mcnt_a = (mcnt_a + 1) % 256;
      end
      if (mq_b.size() != 0 && b_ready) begin
        void'(mq_b.pop_front());
        mcnt_b = (mcnt_b + 1) % 256;
      end
      if (m_acc) begin
        if (in_sel) mq_b.push_back(in_data);
        else        mq_a.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("a_valid", a_valid, mq_a.size() != 0);
      check("b_valid", b_valid, mq_b.size() != 0);
      if (mq_a.size() != 0) check("a_data", a_data, mq_a[0]);
      if (mq_b.size() != 0) check("b_data", b_data, mq_b[0]);
      check("a_count", a_count, mcnt_a);
      check("b_count", b_count, mcnt_b);
      check("in_ready", in_ready, m_rdy(in_sel));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic send(input logic [W-1:0] d, input logic s, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      #1;
      done = in_ready;
      @(posedge clk);
      #1;
      if (!done) waits++;
    end
    in_valid = 1'b0;
    check("send_timeout", done, 1'b1);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  int w;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_sel   = 1'b0;
    in_data  = 16'h5555;
    a_ready  = 1'b1;
    b_ready  = 1'b1;

    // Reset held 3 cycles with a word offered.
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", a_valid, 1'b0);
    check("rst_b_valid", b_valid, 1'b0);
    check("rst_a_data",  a_data,  16'h0000);
    check("rst_b_data",  b_data,  16'h0000);
    check("rst_a_count", a_count, 8'd0);
    check("rst_b_count", b_count, 8'd0);
    reset_n  = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("rst_no_accept", a_valid, 1'b0);

    // Basic steering.
    send(16'h1234, 1'b0, w);
    check("steer_a_valid", a_valid, 1'b1);
    check("steer_a_data",  a_data,  16'h1234);
    send(16'hABCD, 1'b1, w);
    check("steer_a_gone",  a_valid, 1'b0);
    check("steer_b_valid", b_valid, 1'b1);
    check("steer_b_data",  b_data,  16'hABCD);
    repeat (2) @(posedge clk);
    #1;
    check("steer_a_count", a_count, 8'd1);
    check("steer_b_count", b_count, 8'd1);

    // Independent stall: A blocked, B keeps flowing.
    do_reset(1);
    a_ready = 1'b0;
    send(16'h0001, 1'b0, w);
    send(16'h0002, 1'b1, w);
    send(16'h0003, 1'b1, w);
    check("stall_b_waits", w, 0);
    repeat (2) @(posedge clk);
    #1;
    check("stall_b_count", b_count, 8'd2);
    check("stall_a_valid", a_valid, 1'b1);
    check("stall_a_data",  a_data,  16'h0001);
`ifdef DEMUX_SKID_EN
    send(16'h0004, 1'b0, w);
    check("stall_skid_take", w, 0);
`endif
    in_data  = 16'h0005;
    in_sel   = 1'b0;
    in_valid = 1'b1;
    #1;
    check("stall_a_full", in_ready, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stall_a_hold", a_data, 16'h0001);
    a_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stall_a_drained", a_valid, 1'b0);

    // Back-to-back streaming, alternating A/B.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      send(16'(i), i[0], w);
      check("stream_1pc", w, 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("stream_a_count", a_count, 8'd10);
    check("stream_b_count", b_count, 8'd10);

    // Count wrap on A.
    do_reset(1);
    for (int i = 0; i < 255; i++) send(16'(i), 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_255", a_count, 8'd255);
    check("wrap_b0_a", b_count, 8'd0);
    send(16'h00FF, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_0", a_count, 8'd0);
    send(16'h0100, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    check("wrap_1", a_count, 8'd1);
    check("wrap_b0_b", b_count, 8'd0);

    // Reset mid-operation with both buffers full and consumers stalled.
    do_reset(1);
    a_ready = 1'b0;
    b_ready = 1'b0;
    for (int i = 0; i < CAP; i++) begin
      send(16'hA000 + 16'(i), 1'b0, w);
      send(16'hB000 + 16'(i), 1'b1, w);
    end
    check("mid_a_full", a_valid, 1'b1);
    check("mid_b_full", b_valid, 1'b1);
    do_reset(1);
    check("mid_a_valid", a_valid, 1'b0);
    check("mid_b_valid", b_valid, 1'b0);
    check("mid_a_count", a_count, 8'd0);
    check("mid_b_count", b_count, 8'd0);
    a_ready = 1'b1;
    b_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("mid_no_stale_a", a_valid, 1'b0);
    check("mid_no_stale_b", b_valid, 1'b0);
    check("mid_cnt_a", a_count, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/demux_1x2_stream.md
# demux_1x2_stream

- Registered 1-to-2 stream demultiplexer: steers each WIDTH-bit word from a single valid/ready source to output A or B, selected per word by `in_sel`.
- Counterpart to the datapath 2-to-1 selectors: where a producer must feed one of two consumers (e.g. ALU result to register-file write-back or memory write port) with backpressure honoured independently on each side.
- Each output has its own buffer, so a stalled consumer never corrupts or drops words bound for the other.

## Interface
- `WIDTH`, default 16, data word width.
- `clk` input 1 — rising-edge clock.
- `reset_n` input 1 — synchronous, active-low reset.
- `in_data` input WIDTH — word to route.
- `in_sel` input 1 — destination select: 0 = A, 1 = B; sampled with `in_data`.
- `in_valid` input 1 — source offers a word.
- `in_ready` output 1 — block accepts the word this cycle.
- `a_data` output WIDTH — word presented to consumer A.
- `a_valid` output 1 — `a_data` is valid.
- `a_ready` input 1 — consumer A takes the word.
- `b_data`, `b_valid`, `b_ready` — same as the A signals, for consumer B.
- `a_count` output 8 — number of words delivered on A; wraps.
- `b_count` output 8 — number of words delivered on B; wraps.

## Operation
- Accept: `in_valid && in_ready` on a rising edge. The word enters the buffer of the output selected by `in_sel`.
- Deliver: `x_valid && x_ready` on a rising edge, where x is A or B. The head word leaves that buffer and `x_count` increments modulo 256 (255 -> 0).
- `in_ready` is a function of `in_sel` and the selected output's buffer state only. The unselected output's state has no effect.
- Per-output order is strictly FIFO. There is no ordering guarantee between A and B.
- While `x_valid` is high and `x_ready` is low, `x_data` and `x_valid` hold stable.
- `x_data` after a delivery with nothing queued keeps its last value (don't-care); the bench checks data only when `x_valid` is high.
- Each output buffer tracks occupancy (empty / one entry, or up to two with skid enabled). There is no other state machine; the two output paths are fully independent.
- Reset: `a_valid = b_valid = 0`, `a_data = b_data = 0`, `a_count = b_count = 0`, all buffers empty. `in_ready` follows from an empty buffer (1).
- Reset mid-operation discards all buffered words. Counts clear, and no delivery is signalled in the reset cycle.

## Timing
- Latency: a word accepted at edge N is presented with `x_valid = 1` after edge N, so it can deliver at edge N+1 at the earliest.
- Throughput: one word per cycle per input, sustained when the selected consumer holds ready high.
- Default build: one-entry register per output.
  - `in_ready = !x_valid || x_ready` for the selected x, so `x_ready` feeds `in_ready` combinationally.
  - Accept and deliver on the same output in the same cycle reloads the register; `x_valid` stays 1 and the new data appears the next cycle.
- A simultaneous accept to A and delivery from B are independent; both take effect.

## Configuration
- `DEMUX_SKID_EN` defined: each output holds a 2-entry FIFO (skid buffer).
  - `in_ready = (occupancy of selected output < 2)`, computed from registers only, with no combinational path from `x_ready`.
  - Accept plus deliver on the same output leaves occupancy unchanged.
  - Full (2 entries) with `x_ready` low forces `in_ready = 0` for that selection.
  - Full with `x_ready` high still reports `in_ready = 0` in that cycle; ready rises after the delivery edge.
- `DEMUX_SKID_EN` undefined: single-register behaviour as in Timing above.
- Ports, reset values and latency are identical in both builds.

## Test plan
- **Reset:** hold `reset_n = 0` 3 cycles with `in_valid = 1`.
  - Required: `a_valid = b_valid = 0`, counts 0, no accept recorded.
  - After release: `in_ready = 1`.
- **Basic steering:** send 0x1234 with sel 0, then 0xABCD with sel 1, both consumers ready.
  - Required: `a_data = 0x1234`, `a_valid` for 1 cycle after accept; `b_data = 0xABCD` one cycle later.
  - Counts end at 1 and 1.
- **Independent stall:** `a_ready = 0`, then send 0x0001 (A), 0x0002 (B), 0x0003 (B).
  - Required: B delivers 0x0002 then 0x0003 while `a_data` holds 0x0001 stable.
  - A further A word sees `in_ready = 0` (default build) or is accepted (skid build), then `in_ready = 0` on the next A word.
- **Back-to-back streaming:** 20 words alternating A/B with data = index, both consumers always ready.
  - Required: one accept per cycle, per-output order preserved, `a_count = b_count = 10`.
- **Count wrap:** deliver 257 words to A.
  - Required: `a_count` reads 255 after word 255, 0 after word 256, 1 after word 257; `b_count = 0` throughout.
- **Reset mid-operation:** fill both buffers with consumers stalled, then pulse `reset_n = 0` for 1 cycle.
  - Required: valids drop to 0, counts 0, and no stale word appears after consumers go ready.
